// File: rtl/beatmap_pkg.sv
// Shared note types and helpers for the beatmap note path.
package beatmap_pkg;

    localparam int NOTE_W = 8;
    localparam int LANE_W = 2;

    typedef logic [NOTE_W-1:0] note_t;
    typedef logic [LANE_W-1:0] lane_t;

    // The lane index lives in bits [3:2] of every generator note code.
    function automatic lane_t lane_of(input note_t note);
        return note[3:2];
    endfunction

endpackage

// File: rtl/beatmap_note_scheduler_note_fifo.sv
// First-word-fall-through note FIFO.
// The head entry is read straight from storage, so a note written into an
// empty FIFO is visible the cycle after the write. A push while full is only
// accepted when the head is popped in the same cycle; otherwise it is
// silently ignored and the caller decides what that means.
module note_fifo
    import beatmap_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  note_t            push_data,
    input  logic             pop_req,
    output note_t            head_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    note_t            mem_q [DEPTH];
    note_t            mem_d [DEPTH];

    logic pop;
    logic push_ok;

    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // A pop needs a note at the head; a push into a full FIFO needs a
    // simultaneous pop to free the slot it will reuse.
    always_comb begin
        pop     = pop_req && !empty;
        push_ok = push && (!full || pop);
    end

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage next-state: only the tail slot is written, on an accepted push.
    always_comb begin
        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
        end
    end

    // Control state; reset empties the FIFO by clearing pointers and count.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Note storage is deliberately left out of reset; stale entries are
    // never visible because the count gates validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/beatmap_note_scheduler.sv
// Beat-rate sampler of the generator note stream.
// A beat counter advances on every cycle where the generator is valid and
// the scheduler is enabled; the last count of each beat is the sample
// cycle, whose data is pushed into a FWFT FIFO that feeds the renderer.
// A sample that finds the FIFO full with no pop pending is lost and raises
// a sticky overflow flag until reset.
module beatmap_note_scheduler
    import beatmap_pkg::*;
#(
    parameter int BEAT_PERIOD = 16,
    parameter int DEPTH       = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic                    data_en,
    input  logic [NOTE_W-1:0]       data,
    output logic                    note_valid,
    output logic [NOTE_W-1:0]       note_data,
    output logic [LANE_W-1:0]       note_lane,
    input  logic                    note_ready,
    output logic                    beat_tick,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);

    localparam int               BEAT_W    = $clog2(BEAT_PERIOD);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_PERIOD - 1);
    localparam int               CNT_W     = $clog2(DEPTH) + 1;

    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              overflow_q, overflow_d;

    logic              active;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    note_t             fifo_head;
    logic [CNT_W-1:0]  fifo_count;

    assign active = enable && data_en;

    // The sample cycle is the active cycle on the final count of the beat.
    always_comb begin
        beat_tick = active && (beat_cnt_q == BEAT_LAST);
    end

    // Beat counter: a gap in the generator stream restarts the beat, while
    // a pause with the stream still valid merely holds it.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (!data_en) begin
            beat_cnt_d = '0;
        end else if (enable) begin
            if (beat_cnt_q == BEAT_LAST) begin
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            end
        end
    end

    // Renderer handshake: a pop only happens while a note is presented.
    always_comb begin
        note_valid = !fifo_empty;
        pop        = note_valid && note_ready;
        note_data  = fifo_head;
        note_lane  = lane_of(fifo_head);
        count      = fifo_count;
    end

    // Sticky loss flag: a tick into a full FIFO without a pop drops the sample.
    always_comb begin
        overflow_d = overflow_q;
        if (beat_tick && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
        overflow = overflow_q;
    end

    // Scheduler state registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            beat_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    note_fifo #(
        .DEPTH (DEPTH)
    ) u_note_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (beat_tick),
        .push_data (data),
        .pop_req   (note_ready),
        .head_data (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_beatmap_note_scheduler.sv
// Directed bench for beatmap_note_scheduler with BEAT_PERIOD=4, DEPTH=4.
// Inputs change 1 ns after each rising edge; outputs are sampled on the
// falling edge of the same cycle.
module tb_beatmap_note_scheduler;

    logic       clk;
    logic       resetn;
    logic       enable;
    logic       data_en;
    logic [7:0] data;
    logic       note_valid;
    logic [7:0] note_data;
    logic [1:0] note_lane;
    logic       note_ready;
    logic       beat_tick;
    logic [2:0] count;
    logic       overflow;

    beatmap_note_scheduler #(
        .BEAT_PERIOD (4),
        .DEPTH       (4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (enable),
        .data_en    (data_en),
        .data       (data),
        .note_valid (note_valid),
        .note_data  (note_data),
        .note_lane  (note_lane),
        .note_ready (note_ready),
        .beat_tick  (beat_tick),
        .count      (count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rn;
        logic       en;
        logic       den;
        logic [7:0] d;
        logic       rdy;
        int         e_tick;
        int         e_valid;
        int         e_count;
        int         e_ov;
        logic       cd;
        int         e_data;
        int         e_lane;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic drive(input logic rn, input logic en, input logic den,
                         input logic [7:0] d, input logic rdy);
        @(posedge clk);
        #1;
        resetn     = rn;
        enable     = en;
        data_en    = den;
        data       = d;
        note_ready = rdy;
        @(negedge clk);
    endtask

    task automatic v(input logic rn, input logic en, input logic den,
                     input logic [7:0] d, input logic rdy,
                     input int tk, input int vl, input int cn, input int ov,
                     input logic cd, input int ed, input int el);
        vec_t t;
        t.rn = rn; t.en = en; t.den = den; t.d = d; t.rdy = rdy;
        t.e_tick = tk; t.e_valid = vl; t.e_count = cn; t.e_ov = ov;
        t.cd = cd; t.e_data = ed; t.e_lane = el;
        vecs.push_back(t);
    endtask

    task automatic chk_head(input string name, input int ed, input int el);
        chk({name, " data"}, int'(note_data), ed);
        chk({name, " lane"}, int'(note_lane), el);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int first;
        logic en_k;
        logic den_k;

        resetn = 1'b0; enable = 1'b0; data_en = 1'b0; data = '0; note_ready = 1'b0;

        // Reset held for two cycles with random inputs.
        drive(0, 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
        drive(0, 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
        chk("rst tick", int'(beat_tick), 0);
        chk("rst count", int'(count), 0);
        drive(1, 0, 0, 8'd0, 0);
        chk("rst count post", int'(count), 0);
        chk("rst valid", int'(note_valid), 0);
        chk("rst overflow", int'(overflow), 0);
        chk("rst tick post", int'(beat_tick), 0);

        // Single note, then fill to full, overflow and drain.
        for (int i = 0; i < 3; i++) v(1,1,1,124,1, 0,0,0,0, 0,0,0);
        v(1,1,1,124,1, 1,0,0,0, 0,0,0);
        v(1,1,0,124,1, 0,1,1,0, 1,124,3);
        for (int i = 0; i < 3; i++) v(1,1,1,120,0, 0,0,0,0, 0,0,0);
        v(1,1,1,120,0, 1,0,0,0, 0,0,0);
        for (int i = 0; i < 3; i++) v(1,1,1,124,0, 0,1,1,0, 1,120,2);
        v(1,1,1,124,0, 1,1,1,0, 1,120,2);
        for (int i = 0; i < 3; i++) v(1,1,1,128,0, 0,1,2,0, 1,120,2);
        v(1,1,1,128,0, 1,1,2,0, 1,120,2);
        for (int i = 0; i < 3; i++) v(1,1,1,132,0, 0,1,3,0, 1,120,2);
        v(1,1,1,132,0, 1,1,3,0, 1,120,2);
        for (int i = 0; i < 3; i++) v(1,1,1,136,0, 0,1,4,0, 1,120,2);
        v(1,1,1,136,0, 1,1,4,0, 1,120,2);
        v(1,0,0,0,1, 0,1,4,1, 1,120,2);
        v(1,0,0,0,1, 0,1,3,1, 1,124,3);
        v(1,0,0,0,1, 0,1,2,1, 1,128,0);
        v(1,0,0,0,1, 0,1,1,1, 1,132,1);
        v(1,0,0,0,1, 0,0,0,1, 0,0,0);
        v(1,0,0,0,1, 0,0,0,1, 0,0,0);

        foreach (vecs[i]) begin
            drive(vecs[i].rn, vecs[i].en, vecs[i].den, vecs[i].d, vecs[i].rdy);
            chk($sformatf("v%0d tick", i), int'(beat_tick), vecs[i].e_tick);
            chk($sformatf("v%0d valid", i), int'(note_valid), vecs[i].e_valid);
            chk($sformatf("v%0d count", i), int'(count), vecs[i].e_count);
            chk($sformatf("v%0d overflow", i), int'(overflow), vecs[i].e_ov);
            if (vecs[i].cd) chk_head($sformatf("v%0d head", i), vecs[i].e_data, vecs[i].e_lane);
        end

        // Push and pop in the same cycle while full.
        drive(0, 0, 0, 8'd0, 0);
        for (int i = 0; i < 16; i++) drive(1, 1, 1, 8'(40 + 4 * (i / 4)), 0);
        drive(1, 1, 1, 8'd56, 0);
        chk("full fill count", int'(count), 4);
        chk("full fill overflow", int'(overflow), 0);
        drive(1, 1, 1, 8'd56, 0);
        drive(1, 1, 1, 8'd56, 0);
        drive(1, 1, 1, 8'd56, 1);
        chk("full pp tick", int'(beat_tick), 1);
        chk_head("full pp head before", 40, 2);
        drive(1, 0, 0, 8'd0, 0);
        chk("full pp count", int'(count), 4);
        chk("full pp overflow", int'(overflow), 0);
        chk_head("full pp head after", 44, 3);

        // Build 3 queued notes with overflow set, then reset mid-operation.
        for (int i = 0; i < 4; i++) drive(1, 1, 1, 8'd60, 0);
        chk("drop tick", int'(beat_tick), 1);
        drive(1, 0, 0, 8'd0, 1);
        chk("drop overflow", int'(overflow), 1);
        chk("drop count", int'(count), 4);
        drive(1, 0, 0, 8'd0, 0);
        chk("pre-rst count", int'(count), 3);
        chk("pre-rst overflow", int'(overflow), 1);
        drive(0, 1, 1, 8'd0, 0);
        first = 0;
        for (int k = 1; k <= 12 && first == 0; k++) begin
            drive(1, 1, 1, 8'd200, 1);
            if (k == 1) begin
                chk("midrst count", int'(count), 0);
                chk("midrst valid", int'(note_valid), 0);
                chk("midrst overflow", int'(overflow), 0);
            end
            if (beat_tick) first = k;
        end
        chk("midrst first tick cycle", first, 4);

        // Pause: enable low for 3 cycles after the 2nd active cycle.
        first = 0;
        for (int k = 1; k <= 12 && first == 0; k++) begin
            en_k = !(k >= 3 && k <= 5);
            drive(1, en_k, 1, 8'd16, 1);
            if (beat_tick) first = k;
        end
        chk("pause tick cycle", first, 7);

        // Gap: data_en low for one cycle restarts the beat.
        first = 0;
        for (int k = 1; k <= 12 && first == 0; k++) begin
            den_k = (k != 3);
            drive(1, 1, den_k, 8'd20, 1);
            if (beat_tick) first = k;
        end
        chk("gap tick cycle", first, 7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
